gate_truth_checker: RTL and testbench



---
 rtl/gate_truth_checker.sv | 72 +++++++
 tb/tb_gate_truth_checker.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: drives all four {A,B} vectors into a 2-input gate and checks Y against a truth table
module gate_truth_checker #(
  parameter int         SETTLE = 4,
  parameter logic [3:0] TRUTH  = 4'b1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       Y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [7:0] LAST = 8'(SETTLE - 1);
  state_t     state;
  logic [1:0] idx;
  logic [7:0] cnt;
  logic [3:0] next_mask;
  // mask including the vector sampled on this edge, so pass sees the final result
  always_comb begin
    next_mask = fail_mask;
    next_mask[idx] = (Y != TRUTH[idx]);
  end
  // run sequencer: hold each vector SETTLE cycles, sample Y on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= 8'd0;
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 4'd0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          idx       <= 2'd0;
          cnt       <= 8'd0;
          A         <= 1'b0;
          B         <= 1'b0;
          busy      <= 1'b1;
          fail_mask <= 4'd0;
          pass      <= 1'b0;
          state     <= RUN;
        end
      end else if (cnt != LAST) begin
        cnt <= cnt + 8'd1;
      end else begin
        fail_mask <= next_mask;
        if (idx != 2'd3) begin
          idx    <= idx + 2'd1;
          {A, B} <= idx + 2'd1;
          cnt    <= 8'd0;
        end else begin
          A     <= 1'b0;
          B     <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (next_mask == 4'd0);
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker: scoreboard bench for gate_truth_checker with AND / OR / stuck-at-1 gate models
module tb_gate_truth_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st4 = 1'b0, st1 = 1'b0;
  logic a4, b4, y4, busy4, done4, pass4;
  logic a1, b1, y1, busy1, done1, pass1;
  logic [3:0] mask4, mask1;
  int mode = 0;
  logic sel = 1'b0;
  int tests = 0, fails = 0;
  typedef struct {logic [3:0] mask; logic pass;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  gate_truth_checker #(.SETTLE(4), .TRUTH(4'b1000)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .A(a4), .B(b4), .Y(y4),
    .busy(busy4), .done(done4), .pass(pass4), .fail_mask(mask4));
  gate_truth_checker #(.SETTLE(1), .TRUTH(4'b1000)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .A(a1), .B(b1), .Y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_mask(mask1));

  function automatic logic gate(input int m, input logic a, input logic b);
    return m == 0 ? (a & b) : m == 1 ? (a | b) : 1'b1;
  endfunction

  assign y4 = gate(mode, a4, b4);
  assign y1 = gate(mode, a1, b1);

  logic o_a, o_b, o_busy, o_done, o_pass;
  logic [3:0] o_mask;
  assign o_a    = sel ? a1 : a4;
  assign o_b    = sel ? b1 : b4;
  assign o_busy = sel ? busy1 : busy4;
  assign o_done = sel ? done1 : done4;
  assign o_pass = sel ? pass1 : pass4;
  assign o_mask = sel ? mask1 : mask4;

  // expected result for an AND-table check against gate model m
  function automatic exp_t model(input int m);
    exp_t e;
    logic [1:0] v;
    e.mask = 4'd0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      e.mask[i] = gate(m, v[1], v[0]) != (i == 3);
    end
    e.pass = (e.mask == 4'd0);
    return e;
  endfunction

  // called at a negedge; chain leaves us in the done cycle for a back-to-back start
  task automatic run(input int m, input logic fast, input logic hold, input logic chain);
    int s;
    int nk;
    exp_t e;
    logic [1:0] v;
    s = fast ? 1 : 4;
    sel = fast;
    mode = m;
    if (fast) st1 = 1'b1; else st4 = 1'b1;
    sb.push_back(model(m));
    @(negedge clk);
    if (!hold) begin st1 = 1'b0; st4 = 1'b0; end
    nk = 4 * s;
    for (int k = 0; k < nk; k++) begin
      v = 2'(k / s);
      tests++;
      if (o_busy !== 1'b1) begin fails++; $display("FAIL busy m%0d k%0d: got %b want 1", m, k, o_busy); end
      tests++;
      if ({o_a, o_b} !== v) begin fails++; $display("FAIL vector m%0d k%0d: got %b want %b", m, k, {o_a, o_b}, v); end
      tests++;
      if (o_done !== 1'b0) begin fails++; $display("FAIL early_done m%0d k%0d: got %b want 0", m, k, o_done); end
      if (k == 0) begin
        tests++;
        if ({o_mask, o_pass} !== 5'b0) begin fails++; $display("FAIL start_clear m%0d: got mask %b pass %b want 0000 0", m, o_mask, o_pass); end
      end
      @(negedge clk);
    end
    st1 = 1'b0;
    st4 = 1'b0;
    tests++;
    if ({o_done, o_busy, o_a, o_b} !== 4'b1000) begin fails++; $display("FAIL end_flags m%0d: got done/busy/A/B %b want 1000", m, {o_done, o_busy, o_a, o_b}); end
    tests++;
    if (sb.size() == 0) begin
      fails++; $display("FAIL scoreboard m%0d: got empty queue want entry", m);
    end else begin
      e = sb.pop_front();
      if (o_mask !== e.mask || o_pass !== e.pass) begin fails++; $display("FAIL result m%0d: got mask %b pass %b want mask %b pass %b", m, o_mask, o_pass, e.mask, e.pass); end
    end
    if (!chain) begin
      @(negedge clk);
      tests++;
      if ({o_done, o_busy} !== 2'b00) begin fails++; $display("FAIL after_done m%0d: got done/busy %b want 00", m, {o_done, o_busy}); end
      tests++;
      if (o_mask !== e.mask || o_pass !== e.pass) begin fails++; $display("FAIL held m%0d: got mask %b pass %b want %b %b", m, o_mask, o_pass, e.mask, e.pass); end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({a4, b4, busy4, done4, pass4, mask4, a1, b1, busy1, done1, pass1, mask1} !== 18'b0) begin
      fails++; $display("FAIL reset: got %b want all 0", {a4, b4, busy4, done4, pass4, mask4, a1, b1, busy1, done1, pass1, mask1});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_good_and;    run(0, 1'b0, 1'b0, 1'b0); endtask
  task automatic test_or_model;    run(1, 1'b0, 1'b0, 1'b0); endtask
  task automatic test_stuck_one;   run(2, 1'b0, 1'b0, 1'b0); endtask
  task automatic test_hold_start;  run(0, 1'b0, 1'b1, 1'b0); endtask
  task automatic test_back_to_back;
    run(2, 1'b0, 1'b0, 1'b1);
    run(0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_min_settle;
    run(0, 1'b1, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run;
    sel = 1'b0;
    mode = 0;
    st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    repeat (9) @(negedge clk);
    tests++;
    if ({a4, b4} !== 2'b10) begin fails++; $display("FAIL pre_reset_vector: got %b want 10", {a4, b4}); end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({a4, b4, busy4, done4, pass4, mask4} !== 8'b0) begin fails++; $display("FAIL async_reset: got %b want 00000000", {a4, b4, busy4, done4, pass4, mask4}); end
    repeat (2) @(negedge clk);
    tests++;
    if ({a4, b4, busy4, done4, pass4, mask4} !== 8'b0) begin fails++; $display("FAIL reset_hold: got %b want 00000000", {a4, b4, busy4, done4, pass4, mask4}); end
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_good_and();
    test_or_model();
    test_stuck_one();
    test_hold_start();
    test_back_to_back();
    test_reset_mid_run();
    test_min_settle();
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
